// File: rtl/fetch_sequencer.sv
// PC controller: fetches one instruction at a time over a wait-state handshake, then applies
// stall/halt/jump/branch control. Define FETCH_TRAP_EN to trap misaligned jump targets.
module fetch_sequencer #(
  parameter int unsigned     PC_W        = 32,
  parameter logic [PC_W-1:0] RESET_VEC   = '0,
  parameter logic [5:0]      HALT_OPCODE = 6'h3F,
  parameter logic [PC_W-1:0] TRAP_VEC    = PC_W'(32'h100)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            imem_rdy,
  input  logic [31:0]     inscode,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [31:0]     br_offset,
  input  logic            jmp,
  input  logic [PC_W-1:0] jmp_target,
  input  logic            resume,
  output logic [PC_W-1:0] pc,
  output logic            imem_req,
  output logic            ins_valid,
  output logic [31:0]     ins_out,
  output logic            halted,
  output logic            trap
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

  state_t          state, state_nx;
  logic [PC_W-1:0] pc_nx;
  logic [PC_W-1:0] br_step;
  logic [31:0]     ins_nx;
  logic            trap_nx;

`ifndef FETCH_TRAP_EN
  logic jmp_lsb_unused;
  assign jmp_lsb_unused = ^jmp_target[1:0];
`endif

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    ins_nx   = ins_out;
    trap_nx  = 1'b0;
    br_step  = PC_W'($signed(br_offset)) << 2;
    case (state)
      IDLE:  state_nx = FETCH;
      FETCH: begin
        if (imem_rdy) begin
          ins_nx   = inscode;
          state_nx = EXEC;
        end
      end
      EXEC: begin
        if (!stall) begin
          if (ins_out[31:26] == HALT_OPCODE) begin
            state_nx = HALT;
          end else begin
            state_nx = FETCH;
            if (jmp) begin
`ifdef FETCH_TRAP_EN
              if (jmp_target[1:0] != 2'b00) begin
                pc_nx   = TRAP_VEC;
                trap_nx = 1'b1;
              end else begin
                pc_nx = {jmp_target[PC_W-1:2], 2'b00};
              end
`else
              pc_nx = {jmp_target[PC_W-1:2], 2'b00};
`endif
            end else if (br_taken) begin
              pc_nx = pc + PC_W'(4) + br_step;
            end else begin
              pc_nx = pc + PC_W'(4);
            end
          end
        end
      end
      HALT: begin
        if (resume) begin
          pc_nx    = pc + PC_W'(4);
          state_nx = FETCH;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      pc        <= RESET_VEC;
      ins_out   <= '0;
      trap      <= 1'b0;
      imem_req  <= 1'b0;
      ins_valid <= 1'b0;
      halted    <= 1'b0;
    end else begin
      state     <= state_nx;
      pc        <= pc_nx;
      ins_out   <= ins_nx;
      trap      <= trap_nx;
      imem_req  <= (state_nx == FETCH);
      ins_valid <= (state_nx == EXEC);
      halted    <= (state_nx == HALT);
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: instruction memory model returns a pc-derived word,
// expected fetches are queued and popped when the sequencer presents each instruction.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_rdy = 1'b1;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic        jmp = 1'b0;
  logic        resume = 1'b0;
  logic [31:0] br_offset = '0;
  logic [31:0] jmp_target = '0;
  logic [31:0] halt_pc = 32'hFFFF_FFF0;
  logic [31:0] inscode;
  logic [31:0] pc, ins_out;
  logic        imem_req, ins_valid, halted, trap;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  always #5 clk = ~clk;

  assign inscode = (pc == halt_pc) ? 32'hFC00_0000 : {6'h01, pc[25:0]};

  fetch_sequencer #(
    .PC_W(32), .RESET_VEC(32'h0), .HALT_OPCODE(6'h3F), .TRAP_VEC(32'h100)
  ) dut (
    .clk(clk), .reset(reset), .imem_rdy(imem_rdy), .inscode(inscode), .stall(stall),
    .br_taken(br_taken), .br_offset(br_offset), .jmp(jmp), .jmp_target(jmp_target),
    .resume(resume), .pc(pc), .imem_req(imem_req), .ins_valid(ins_valid),
    .ins_out(ins_out), .halted(halted), .trap(trap)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a == halt_pc) ? 32'hFC00_0000 : {6'h01, a[25:0]};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] a);
    exp_t x;
    x.pc  = a;
    x.ins = word_at(a);
    sb.push_back(x);
  endtask

  task automatic test_reset;
    #12;
    n_chk++;
    if (pc !== 32'h0) begin
      n_fail++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0);
    end
    n_chk++;
    if ({imem_req, ins_valid, halted, trap} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 0000", {imem_req, ins_valid, halted, trap});
    end
    n_chk++;
    if (ins_out !== 32'h0) begin
      n_fail++; $display("FAIL reset_ins: got %h expected %h", ins_out, 32'h0);
    end
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic test_sequential;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a;
      a = 32'(i * 4);
      tick;
      n_chk++;
      if (imem_req !== 1'b1 || ins_valid !== 1'b0 || pc !== a) begin
        n_fail++; $display("FAIL seq_fetch: req=%b valid=%b pc=%h expected 1 0 %h", imem_req, ins_valid, pc, a);
      end
      push_exp(a);
      tick;
      e = sb.pop_front();
      n_chk++;
      if (ins_valid !== 1'b1 || imem_req !== 1'b0 || pc !== e.pc || ins_out !== e.ins) begin
        n_fail++; $display("FAIL seq_exec: valid=%b req=%b pc=%h ins=%h expected 1 0 %h %h", ins_valid, imem_req, pc, ins_out, e.pc, e.ins);
      end
    end
  endtask

  task automatic test_wait_states;
    imem_rdy = 1'b0;
    tick;
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (imem_req !== 1'b1 || ins_valid !== 1'b0 || pc !== 32'h10) begin
        n_fail++; $display("FAIL wait_fetch%0d: req=%b valid=%b pc=%h expected 1 0 00000010", i, imem_req, ins_valid, pc);
      end
      if (i == 3) begin
        imem_rdy = 1'b1;
        push_exp(32'h10);
      end
      tick;
    end
    e = sb.pop_front();
    n_chk++;
    if (ins_valid !== 1'b1 || pc !== e.pc || ins_out !== e.ins) begin
      n_fail++; $display("FAIL wait_exec: valid=%b pc=%h ins=%h expected 1 %h %h", ins_valid, pc, ins_out, e.pc, e.ins);
    end
  endtask

  task automatic test_branch;
    br_taken = 1'b1; br_offset = 32'hFFFF_FFFE;
    tick;
    br_taken = 1'b0; br_offset = '0;
    n_chk++;
    if (pc !== 32'h0C || imem_req !== 1'b1) begin
      n_fail++; $display("FAIL branch_back: pc=%h req=%b expected 0000000c 1", pc, imem_req);
    end
    push_exp(32'h0C);
    tick;
    e = sb.pop_front();
    n_chk++;
    if (ins_valid !== 1'b1 || pc !== e.pc || ins_out !== e.ins) begin
      n_fail++; $display("FAIL branch_exec: valid=%b pc=%h ins=%h expected 1 %h %h", ins_valid, pc, ins_out, e.pc, e.ins);
    end
    jmp = 1'b1; br_taken = 1'b1; br_offset = 32'h10; jmp_target = 32'h40;
    tick;
    jmp = 1'b0; br_taken = 1'b0; br_offset = '0;
    n_chk++;
    if (pc !== 32'h40 || imem_req !== 1'b1) begin
      n_fail++; $display("FAIL jmp_over_br: pc=%h req=%b expected 00000040 1", pc, imem_req);
    end
    push_exp(32'h40);
    tick;
    e = sb.pop_front();
    n_chk++;
    if (ins_valid !== 1'b1 || pc !== e.pc || ins_out !== e.ins) begin
      n_fail++; $display("FAIL jmp_exec: valid=%b pc=%h ins=%h expected 1 %h %h", ins_valid, pc, ins_out, e.pc, e.ins);
    end
  endtask

  task automatic test_stall;
    stall = 1'b1; jmp = 1'b1; br_taken = 1'b1; br_offset = 32'h4; jmp_target = 32'h80;
    for (int i = 0; i < 5; i++) begin
      tick;
      n_chk++;
      if (ins_valid !== 1'b1 || imem_req !== 1'b0 || pc !== 32'h40 || ins_out !== word_at(32'h40)) begin
        n_fail++; $display("FAIL stall_hold%0d: valid=%b req=%b pc=%h ins=%h expected 1 0 00000040 %h", i, ins_valid, imem_req, pc, ins_out, word_at(32'h40));
      end
    end
    stall = 1'b0;
    tick;
    jmp = 1'b0; br_taken = 1'b0; br_offset = '0;
    n_chk++;
    if (pc !== 32'h80 || ins_valid !== 1'b0 || imem_req !== 1'b1) begin
      n_fail++; $display("FAIL stall_release: pc=%h valid=%b req=%b expected 00000080 0 1", pc, ins_valid, imem_req);
    end
    push_exp(32'h80);
    tick;
    e = sb.pop_front();
    n_chk++;
    if (ins_valid !== 1'b1 || pc !== e.pc || ins_out !== e.ins) begin
      n_fail++; $display("FAIL stall_exec: valid=%b pc=%h ins=%h expected 1 %h %h", ins_valid, pc, ins_out, e.pc, e.ins);
    end
  endtask

  task automatic test_halt;
    halt_pc = 32'h84;
    tick;
    push_exp(32'h84);
    tick;
    e = sb.pop_front();
    n_chk++;
    if (ins_valid !== 1'b1 || pc !== e.pc || ins_out !== e.ins) begin
      n_fail++; $display("FAIL halt_exec: valid=%b pc=%h ins=%h expected 1 %h %h", ins_valid, pc, ins_out, e.pc, e.ins);
    end
    jmp = 1'b1; jmp_target = 32'h200;
    tick;
    jmp = 1'b0;
    n_chk++;
    if (halted !== 1'b1 || ins_valid !== 1'b0 || imem_req !== 1'b0 || pc !== 32'h84) begin
      n_fail++; $display("FAIL halt_enter: halted=%b valid=%b req=%b pc=%h expected 1 0 0 00000084", halted, ins_valid, imem_req, pc);
    end
    tick;
    tick;
    n_chk++;
    if (halted !== 1'b1 || imem_req !== 1'b0 || pc !== 32'h84) begin
      n_fail++; $display("FAIL halt_stay: halted=%b req=%b pc=%h expected 1 0 00000084", halted, imem_req, pc);
    end
    resume = 1'b1;
    halt_pc = 32'hFFFF_FFF0;
    tick;
    resume = 1'b0;
    n_chk++;
    if (halted !== 1'b0 || imem_req !== 1'b1 || pc !== 32'h88) begin
      n_fail++; $display("FAIL resume: halted=%b req=%b pc=%h expected 0 1 00000088", halted, imem_req, pc);
    end
    push_exp(32'h88);
    tick;
    e = sb.pop_front();
    n_chk++;
    if (ins_valid !== 1'b1 || pc !== e.pc || ins_out !== e.ins) begin
      n_fail++; $display("FAIL resume_exec: valid=%b pc=%h ins=%h expected 1 %h %h", ins_valid, pc, ins_out, e.pc, e.ins);
    end
  endtask

  task automatic test_wrap;
    jmp = 1'b1; jmp_target = 32'hFFFF_FFFC;
    tick;
    jmp = 1'b0;
    n_chk++;
    if (pc !== 32'hFFFF_FFFC) begin
      n_fail++; $display("FAIL wrap_jmp: pc=%h expected fffffffc", pc);
    end
    push_exp(32'hFFFF_FFFC);
    tick;
    e = sb.pop_front();
    n_chk++;
    if (ins_valid !== 1'b1 || pc !== e.pc || ins_out !== e.ins) begin
      n_fail++; $display("FAIL wrap_exec: valid=%b pc=%h ins=%h expected 1 %h %h", ins_valid, pc, ins_out, e.pc, e.ins);
    end
    tick;
    n_chk++;
    if (pc !== 32'h0 || imem_req !== 1'b1) begin
      n_fail++; $display("FAIL wrap_zero: pc=%h req=%b expected 00000000 1", pc, imem_req);
    end
    push_exp(32'h0);
    tick;
    e = sb.pop_front();
    n_chk++;
    if (ins_valid !== 1'b1 || pc !== e.pc || ins_out !== e.ins) begin
      n_fail++; $display("FAIL wrap_exec0: valid=%b pc=%h ins=%h expected 1 %h %h", ins_valid, pc, ins_out, e.pc, e.ins);
    end
  endtask

  task automatic test_trap(output logic [31:0] ta);
    logic exp_trap;
`ifdef FETCH_TRAP_EN
    ta = 32'h100; exp_trap = 1'b1;
`else
    ta = 32'h40;  exp_trap = 1'b0;
`endif
    jmp = 1'b1; jmp_target = 32'h42;
    tick;
    jmp = 1'b0;
    n_chk++;
    if (pc !== ta || trap !== exp_trap || imem_req !== 1'b1) begin
      n_fail++; $display("FAIL misaligned_jmp: pc=%h trap=%b req=%b expected %h %b 1", pc, trap, imem_req, ta, exp_trap);
    end
    push_exp(ta);
    tick;
    n_chk++;
    if (trap !== 1'b0) begin
      n_fail++; $display("FAIL trap_pulse: trap=%b expected 0", trap);
    end
    e = sb.pop_front();
    n_chk++;
    if (ins_valid !== 1'b1 || pc !== e.pc || ins_out !== e.ins) begin
      n_fail++; $display("FAIL trap_exec: valid=%b pc=%h ins=%h expected 1 %h %h", ins_valid, pc, ins_out, e.pc, e.ins);
    end
  endtask

  task automatic test_reset_mid;
    jmp = 1'b1; jmp_target = 32'h20;
    tick;
    jmp = 1'b0; imem_rdy = 1'b0;
    tick;
    n_chk++;
    if (pc !== 32'h20 || imem_req !== 1'b1) begin
      n_fail++; $display("FAIL mid_fetch: pc=%h req=%b expected 00000020 1", pc, imem_req);
    end
    #2 reset = 1'b0;
    #1;
    n_chk++;
    if (pc !== 32'h0 || ins_out !== 32'h0) begin
      n_fail++; $display("FAIL async_reset_pc: pc=%h ins=%h expected 00000000 00000000", pc, ins_out);
    end
    n_chk++;
    if ({imem_req, ins_valid, halted, trap} !== 4'b0000) begin
      n_fail++; $display("FAIL async_reset_flags: got %b expected 0000", {imem_req, ins_valid, halted, trap});
    end
    @(negedge clk);
    reset = 1'b1; imem_rdy = 1'b1;
    tick;
    n_chk++;
    if (pc !== 32'h0 || imem_req !== 1'b1 || ins_valid !== 1'b0) begin
      n_fail++; $display("FAIL restart_fetch: pc=%h req=%b valid=%b expected 00000000 1 0", pc, imem_req, ins_valid);
    end
    push_exp(32'h0);
    tick;
    e = sb.pop_front();
    n_chk++;
    if (ins_valid !== 1'b1 || pc !== e.pc || ins_out !== e.ins) begin
      n_fail++; $display("FAIL restart_exec: valid=%b pc=%h ins=%h expected 1 %h %h", ins_valid, pc, ins_out, e.pc, e.ins);
    end
  endtask

  initial begin
    logic [31:0] trap_pc;
    test_reset;
    test_sequential;
    test_wait_states;
    test_branch;
    test_stall;
    test_halt;
    test_wrap;
    test_trap(trap_pc);
    test_reset_mid;
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
